// File: rtl/mem_access_ctrl.sv
// Load/store unit front end: validates one request, drives a single DMEM access and
// captures the raw read word for the writeback stage.
module mem_access_ctrl #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        dmem_en,
  output logic [3:0]  dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] load_word,
  output logic        done,
  output logic        fault,
  output logic        busy
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StFault} state_e;

  localparam logic [1:0] CntLast = 2'(READ_LATENCY - 1);

  state_e      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_data_q, store_data_d;
  logic [31:0] load_word_q, load_word_d;
  logic [1:0]  cnt_q, cnt_d;

  logic       funct3_legal;
  logic       addr_aligned;
  logic       req_ok;
  logic [3:0] size_mask;

  // Request check on the live inputs, used only at accept
  always_comb begin
    funct3_legal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: funct3_legal = 1'b1;
      3'b100, 3'b101:         funct3_legal = !is_store;
      default:                funct3_legal = 1'b0;
    endcase
    addr_aligned = 1'b1;
    case (funct3[1:0])
      2'b01:   addr_aligned = !addr[0];
      2'b10:   addr_aligned = (addr[1:0] == 2'b00);
      default: addr_aligned = 1'b1;
    endcase
    req_ok = funct3_legal && addr_aligned;
  end

  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    store_data_d = store_data_q;
    load_word_d  = load_word_q;
    cnt_d        = cnt_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_ok) begin
            is_store_d   = is_store;
            funct3_d     = funct3;
            addr_d       = addr;
            store_data_d = store_data;
            state_d      = StIssue;
          end else begin
            state_d = StFault;
          end
        end
      end
      StIssue: begin
        cnt_d   = 2'd0;
        state_d = is_store_q ? StResp : StWait;
      end
      StWait: begin
        if (cnt_q == CntLast) begin
          load_word_d = dmem_rdata;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StResp:  state_d = StIdle;
      StFault: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    req_ready  = (state_q == StIdle);
    busy       = (state_q != StIdle);
    done       = (state_q == StResp);
    fault      = (state_q == StFault);
    dmem_en    = (state_q == StIssue);
    dmem_addr  = {addr_q[31:2], 2'b00};
    dmem_we    = (dmem_en && is_store_q) ? (size_mask << addr_q[1:0]) : 4'b0000;
    dmem_wdata = dmem_en ? (store_data_q << {addr_q[1:0], 3'b000}) : 32'h0;
    load_word  = load_word_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= 32'h0;
      store_data_q <= 32'h0;
      load_word_q  <= 32'h0;
      cnt_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      store_data_q <= store_data_d;
      load_word_q  <= load_word_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, a mid-WAIT reset sequence and
// randomized requests checked against a byte-level memory model.
module tb_mem_access_ctrl;

  localparam int unsigned RL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        dmem_en;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic [31:0] load_word;
  logic        done;
  logic        fault;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.READ_LATENCY(RL)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .dmem_en    (dmem_en),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .load_word  (load_word),
    .done       (done),
    .fault      (fault),
    .busy       (busy)
  );

  // DMEM responder: read data is valid exactly RL cycles after the enabled read,
  // otherwise the bus carries junk so a mistimed capture is visible.
  logic        mem_clr;
  logic [31:0] mem [256];
  logic [31:0] pipe_d [RL];
  logic        pipe_v [RL];
  logic [31:0] junk;

  always @(posedge clk) begin
    junk <= $urandom;
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (dmem_en) begin
      for (int i = 0; i < 4; i++)
        if (dmem_we[i]) mem[dmem_addr[9:2]][8*i +: 8] <= dmem_wdata[8*i +: 8];
    end
    if (rst) begin
      for (int i = 0; i < RL; i++) pipe_v[i] <= 1'b0;
    end else begin
      pipe_v[0] <= dmem_en && (dmem_we == 4'b0000);
      for (int i = 1; i < RL; i++) pipe_v[i] <= pipe_v[i-1];
    end
    pipe_d[0] <= mem[dmem_addr[9:2]];
    for (int i = 1; i < RL; i++) pipe_d[i] <= pipe_d[i-1];
  end

  assign dmem_rdata = (pipe_v[RL-1] === 1'b1) ? pipe_d[RL-1] : {16'hBAD0, junk[15:0]};

  // Reference model state
  logic [7:0]  ref_mem [1024];
  logic [31:0] model_lw;
  logic [31:0] model_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic model_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, output logic flt, output logic [3:0] we,
                           output logic [31:0] wd, output logic [31:0] lw);
    int   size;
    int   off;
    int   base;
    logic legal;
    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!st && (f3 == 3'd4 || f3 == 3'd5));
    size  = 1 << f3[1:0];
    off   = int'(a[1:0]);
    base  = int'(a[9:0]) - off;
    flt   = !legal || ((int'(a[9:0]) % size) != 0);
    we    = 4'b0000;
    wd    = d << (8 * off);
    lw    = model_lw;
    if (!flt && st) begin
      for (int b = 0; b < size; b++) begin
        we[off+b]           = 1'b1;
        ref_mem[base+off+b] = d[8*b +: 8];
      end
    end
    if (!flt && !st) lw = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
  endtask

  // Applies one request from IDLE and checks every cycle until back in IDLE.
  task automatic run_req(input string nm, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic flt,
                         input logic [3:0] we, input logic [31:0] wd, input logic [31:0] lw_new);
    int          last;
    logic        issue;
    logic [31:0] exp_addr;
    logic [31:0] lw_after;
    exp_addr = flt ? model_addr : {a[31:2], 2'b00};
    last     = flt ? 1 : (st ? 2 : 2 + RL);
    lw_after = (!flt && !st) ? lw_new : model_lw;
    chk({nm, " ready_pre"}, req_ready, 1'b1);
    req_valid  = 1'b1;
    is_store   = st;
    funct3     = f3;
    addr       = a;
    store_data = d;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk);
      #1;
      if (k < last) begin
        req_valid  = 1'b1;
        is_store   = 1'($urandom_range(0, 1));
        funct3     = 3'($urandom_range(0, 7));
        addr       = $urandom;
        store_data = $urandom;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      issue = (k == 1) && !flt;
      chk($sformatf("%s c%0d busy", nm, k), busy, 1'b1);
      chk($sformatf("%s c%0d ready", nm, k), req_ready, 1'b0);
      chk($sformatf("%s c%0d en", nm, k), dmem_en, issue);
      chk($sformatf("%s c%0d we", nm, k), dmem_we, (issue && st) ? we : 4'b0000);
      chk($sformatf("%s c%0d wdata", nm, k), dmem_wdata, issue ? wd : 32'h0);
      chk($sformatf("%s c%0d daddr", nm, k), dmem_addr, exp_addr);
      chk($sformatf("%s c%0d done", nm, k), done, (k == last) && !flt);
      chk($sformatf("%s c%0d fault", nm, k), fault, (k == last) && flt);
      chk($sformatf("%s c%0d lw", nm, k), load_word, (k == last) ? lw_after : model_lw);
    end
    @(posedge clk);
    @(negedge clk);
    chk({nm, " idle_ready"}, req_ready, 1'b1);
    chk({nm, " idle_busy"}, busy, 1'b0);
    chk({nm, " idle_done"}, done, 1'b0);
    chk({nm, " idle_fault"}, fault, 1'b0);
    chk({nm, " idle_lw"}, load_word, lw_after);
    model_lw = lw_after;
    if (!flt) model_addr = exp_addr;
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic        flt;
    logic [3:0]  we;
    logic [31:0] wd;
    logic [31:0] lw;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic        m_flt;
    logic [3:0]  m_we;
    logic [31:0] m_wd;
    logic [31:0] m_lw;
    logic        r_st;
    logic [2:0]  r_f3;
    logic [31:0] r_a;
    logic [31:0] r_d;

    tbl[0]  = '{1'b1, 3'd2, 32'h040, 32'h12345678, 1'b0, 4'b1111, 32'h12345678, 32'h0};
    tbl[1]  = '{1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0};
    tbl[2]  = '{1'b1, 3'd0, 32'h203, 32'h000000A5, 1'b0, 4'b1000, 32'hA5000000, 32'h0};
    tbl[3]  = '{1'b0, 3'd2, 32'h040, 32'h00000000, 1'b0, 4'b0000, 32'h00000000, 32'h12345678};
    tbl[4]  = '{1'b0, 3'd1, 32'h041, 32'h00000000, 1'b1, 4'b0000, 32'h0, 32'h0};
    tbl[5]  = '{1'b1, 3'd4, 32'h008, 32'h11111111, 1'b1, 4'b0000, 32'h0, 32'h0};
    tbl[6]  = '{1'b0, 3'd4, 32'h203, 32'h00000000, 1'b0, 4'b0000, 32'h00000000, 32'hA5000000};
    tbl[7]  = '{1'b0, 3'd3, 32'h000, 32'h00000000, 1'b1, 4'b0000, 32'h0, 32'h0};
    tbl[8]  = '{1'b1, 3'd2, 32'h102, 32'h22222222, 1'b1, 4'b0000, 32'h0, 32'h0};
    tbl[9]  = '{1'b1, 3'd1, 32'h002, 32'h1234BEEF, 1'b0, 4'b1100, 32'hBEEF0000, 32'h0};
    tbl[10] = '{1'b0, 3'd2, 32'h000, 32'h00000000, 1'b0, 4'b0000, 32'h00000000, 32'hBEEF0000};
    tbl[11] = '{1'b0, 3'd5, 32'h106, 32'h00000000, 1'b0, 4'b0000, 32'h00000000, 32'hDEADBEEF};
    tbl[12] = '{1'b0, 3'd7, 32'h010, 32'h00000000, 1'b1, 4'b0000, 32'h0, 32'h0};
    tbl[13] = '{1'b0, 3'd0, 32'h201, 32'h000000FF, 1'b0, 4'b0000, 32'h0000FF00, 32'hA5000000};

    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    model_lw   = 32'h0;
    model_addr = 32'h0;
    mem_clr    = 1'b1;
    rst        = 1'b1;
    req_valid  = 1'b0;
    is_store   = 1'b0;
    funct3     = 3'd0;
    addr       = 32'h0;
    store_data = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    mem_clr = 1'b0;
    @(negedge clk);
    chk("reset ready", req_ready, 1'b1);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset fault", fault, 1'b0);
    chk("reset en", dmem_en, 1'b0);
    chk("reset we", dmem_we, 4'b0000);
    chk("reset daddr", dmem_addr, 32'h0);
    chk("reset wdata", dmem_wdata, 32'h0);
    chk("reset lw", load_word, 32'h0);

    for (int i = 0; i < 14; i++) begin
      model_req(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].d, m_flt, m_we, m_wd, m_lw);
      run_req($sformatf("vec%0d", i), tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].d,
              tbl[i].flt, tbl[i].we, tbl[i].wd, tbl[i].lw);
    end

    // Reset during the first WAIT cycle of a load aborts it with no done pulse.
    chk("rstwait ready_pre", req_ready, 1'b1);
    req_valid = 1'b1;
    is_store  = 1'b0;
    funct3    = 3'd2;
    addr      = 32'h104;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rstwait issue_en", dmem_en, 1'b1);
    @(negedge clk);
    chk("rstwait wait_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstwait busy", busy, 1'b0);
    chk("rstwait done", done, 1'b0);
    chk("rstwait lw", load_word, 32'h0);
    chk("rstwait en", dmem_en, 1'b0);
    chk("rstwait daddr", dmem_addr, 32'h0);
    chk("rstwait ready", req_ready, 1'b1);
    for (int k = 0; k < int'(RL) + 2; k++) begin
      @(negedge clk);
      chk($sformatf("rstwait nodone%0d", k), done, 1'b0);
    end
    model_lw   = 32'h0;
    model_addr = 32'h0;
    model_req(1'b1, 3'd1, 32'h2, 32'h0000CAFE, m_flt, m_we, m_wd, m_lw);
    run_req("rstwait sh", 1'b1, 3'd1, 32'h2, 32'h0000CAFE, 1'b0, 4'b1100, 32'hCAFE0000, 32'h0);

    for (int n = 0; n < 80; n++) begin
      r_st = 1'($urandom_range(0, 1));
      r_f3 = 3'($urandom_range(0, 7));
      r_a  = 32'($urandom_range(0, 255));
      r_d  = $urandom;
      model_req(r_st, r_f3, r_a, r_d, m_flt, m_we, m_wd, m_lw);
      run_req($sformatf("rnd%0d", n), r_st, r_f3, r_a, r_d, m_flt, m_we, m_wd, m_lw);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
